// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of a single-port data memory. Port 0 is the
// CPU load/store path, port 1 the loader/debug path. Each access walks
// IDLE -> ACCESS -> RESP, so one access completes every three cycles. Only
// this block drives the memory strobes.
//
// Compile-time option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins a tie (no pointer)
//                           undefined : round-robin on ties (default)
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_mN_req/we/addr/wdata       requester N command, req held until gnt
//   o_mN_gnt                     one-cycle pulse in the ACCESS cycle
//   o_mN_rvalid                  one-cycle pulse in the RESP cycle (reads only)
//   o_mN_rdata                   registered read data, held until next read
//   o_mem_addr/wdata/we/re       memory command; strobes only in ACCESS
//   i_mem_rdata                  memory read data, combinational from addr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic              r_cmd_port;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;
  logic              r_m0_gnt;
  logic              r_m1_gnt;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Last-served port; resets to 1 so port 0 wins the first tie.
  logic              r_last;
`endif

  logic              w_issue;
  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_rd_done;

  // Winner selection and command mux for the IDLE sample.
  always_comb begin
    w_issue   = (r_state == S_IDLE) && (i_m0_req || i_m1_req);
    w_rd_done = (r_state == S_ACCESS) && !r_cmd_we;
    w_winner  = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (i_m0_req) begin
      w_winner = 1'b0;
    end else begin
      w_winner = 1'b1;
    end
`else
    // On a tie the port that was not served last goes next.
    if (i_m0_req && i_m1_req) begin
      w_winner = ~r_last;
    end else if (i_m1_req) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
`endif
    if (w_winner) begin
      w_sel_we    = i_m1_we;
      w_sel_addr  = i_m1_addr;
      w_sel_wdata = i_m1_wdata;
    end else begin
      w_sel_we    = i_m0_we;
      w_sel_addr  = i_m0_addr;
      w_sel_wdata = i_m0_wdata;
    end
  end

  // Sequencer: IDLE -> ACCESS -> RESP -> IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= w_issue ? S_ACCESS : S_IDLE;
        S_ACCESS: r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Command register; address/wdata double as the held memory command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd_port  <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else if (w_issue) begin
      r_cmd_port  <= w_winner;
      r_cmd_we    <= w_sel_we;
      r_mem_addr  <= w_sel_addr;
      r_mem_wdata <= w_sel_wdata;
    end
  end

  // Strobes and grant are registered at issue so they cover exactly ACCESS.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_m0_gnt <= 1'b0;
      r_m1_gnt <= 1'b0;
    end else begin
      r_mem_we <= w_issue & w_sel_we;
      r_mem_re <= w_issue & ~w_sel_we;
      r_m0_gnt <= w_issue & ~w_winner;
      r_m1_gnt <= w_issue & w_winner;
    end
  end

  // Read data captured at the end of ACCESS, valid pulse covers RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= {DATA_W{1'b0}};
      r_m1_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_m0_rvalid <= w_rd_done & ~r_cmd_port;
      r_m1_rvalid <= w_rd_done & r_cmd_port;
      if (w_rd_done && !r_cmd_port) begin
        r_m0_rdata <= i_mem_rdata;
      end
      if (w_rd_done && r_cmd_port) begin
        r_m1_rdata <= i_mem_rdata;
      end
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Pointer moves only when an access reaches RESP, so an access killed by
  // reset never counts as served.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (r_state == S_RESP) begin
      r_last <= r_cmd_port;
    end
  end
`endif

  assign o_m0_gnt    = r_m0_gnt;
  assign o_m1_gnt    = r_m1_gnt;
  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter: directed stimulus against dmem_arbiter with a timestamp
// based reference model checked on every falling edge, plus literal checks.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_mem_re(mem_re), .i_mem_rdata(mem_rdata)
  );

  // Bench memory: 256 words aliased on the low address byte.
  logic [15:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 + 16'(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input snapshot taken at each rising edge for the model.
  logic        s_rst;
  logic [1:0]  s_req, s_we;
  logic [15:0] s_addr [2];
  logic [15:0] s_wdata [2];

  always @(posedge clk) begin
    s_rst      <= rst;
    s_req      <= {m1_req, m0_req};
    s_we       <= {m1_we, m0_we};
    s_addr[0]  <= m0_addr;
    s_addr[1]  <= m1_addr;
    s_wdata[0] <= m0_wdata;
    s_wdata[1] <= m1_wdata;
  end

  // Reference model: each access is a record stamped with its sample edge;
  // outputs are derived from the distance between now and that stamp.
  int          k, next_sample, iss_edge, iss_port, last_served, w;
  logic        iss_we;
  logic [15:0] iss_addr, iss_wdata, iss_rdata;
  logic [15:0] mmem [0:255];
  logic [15:0] exp_rdata [2];

  initial begin
    forever begin
      @(negedge clk);
      if (rst || s_rst) begin
        k = 0; next_sample = 0; iss_edge = -10; iss_port = 0; last_served = 1;
        iss_we = 1'b0; iss_addr = 16'h0; iss_wdata = 16'h0; iss_rdata = 16'h0;
        exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
        for (int i = 0; i < 256; i++) mmem[i] = 16'hA500 + 16'(i);
      end else begin
        k++;
        if (k >= next_sample && (s_req[0] || s_req[1])) begin
          if (s_req[0] && s_req[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (last_served == 0) ? 1 : 0;
`endif
          end else begin
            w = s_req[1] ? 1 : 0;
          end
          iss_edge = k; iss_port = w; iss_we = s_we[w];
          iss_addr = s_addr[w]; iss_wdata = s_wdata[w];
          if (iss_we) mmem[iss_addr[7:0]] = iss_wdata;
          else        iss_rdata = mmem[iss_addr[7:0]];
          next_sample = k + 3;
          last_served = w;
        end
        if (iss_edge == k - 1 && !iss_we) exp_rdata[iss_port] = iss_rdata;
      end
      check("m0_gnt",    m0_gnt,    (iss_edge == k) && iss_port == 0);
      check("m1_gnt",    m1_gnt,    (iss_edge == k) && iss_port == 1);
      check("mem_we",    mem_we,    (iss_edge == k) && iss_we);
      check("mem_re",    mem_re,    (iss_edge == k) && !iss_we);
      check("mem_addr",  mem_addr,  iss_addr);
      check("mem_wdata", mem_wdata, iss_wdata);
      check("m0_rvalid", m0_rvalid, (iss_edge == k - 1) && !iss_we && iss_port == 0);
      check("m1_rvalid", m1_rvalid, (iss_edge == k - 1) && !iss_we && iss_port == 1);
      check("m0_rdata",  m0_rdata,  exp_rdata[0]);
      check("m1_rdata",  m1_rdata,  exp_rdata[1]);
    end
  end

  // Stimulus helpers.
  int          gnt_lat, rv_lat, rv_cnt;
  logic [15:0] rv_data, cap_addr, cap_wdata;
  logic        cap_we, cap_re;

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic wait_gnt(input int p, output int lat);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if (p == 0 ? m0_gnt : m1_gnt) begin
        lat = i; cap_we = mem_we; cap_re = mem_re;
        cap_addr = mem_addr; cap_wdata = mem_wdata;
      end
    end
  endtask

  task automatic do_access(input int p, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #2;
    drive(p, 1'b1, we, a, d);
    @(posedge clk);
    wait_gnt(p, gnt_lat);
    drive(p, 1'b0, we, a, d);
    rv_cnt = 0; rv_lat = -1; rv_data = 16'h0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (p == 0 ? m0_rvalid : m1_rvalid) begin
        rv_cnt++;
        if (rv_lat < 0) rv_lat = gnt_lat + i;
        rv_data = (p == 0) ? m0_rdata : m1_rdata;
      end
    end
  endtask

  int n, nz, rv, gc, win;
  int order [4];
  int exp_order [4];
  logic [15:0] rd;

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Quiet after reset.
    nz = 0;
    repeat (10) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt || m0_rvalid || m1_rvalid || mem_we || mem_re ||
          mem_addr != 16'h0 || mem_wdata != 16'h0 || m0_rdata != 16'h0 || m1_rdata != 16'h0)
        nz++;
    end
    check("idle_quiet", nz, 0);

    // Port 0 write.
    do_access(0, 1'b1, 16'h0010, 16'hBEEF);
    check("wr_gnt_lat", gnt_lat, 1);
    check("wr_mem_we", cap_we, 1'b1);
    check("wr_mem_re", cap_re, 1'b0);
    check("wr_mem_addr", cap_addr, 16'h0010);
    check("wr_mem_wdata", cap_wdata, 16'hBEEF);
    check("wr_no_rvalid", rv_cnt, 0);

    // Port 0 read-back.
    do_access(0, 1'b0, 16'h0010, 16'h0000);
    check("rd_gnt_lat", gnt_lat, 1);
    check("rd_mem_re", cap_re, 1'b1);
    check("rd_rvalid_lat", rv_lat, 2);
    check("rd_rvalid_cnt", rv_cnt, 1);
    check("rd_rdata", rv_data, 16'hBEEF);

    // Port 1 write so that port 1 is last served.
    do_access(1, 1'b1, 16'h0030, 16'h1234);
    check("p1_wr_gnt_lat", gnt_lat, 1);

    // Both ports held high for four accesses.
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    order = '{-1, -1, -1, -1};
    @(posedge clk); #2;
    drive(0, 1'b1, 1'b1, 16'h0020, 16'h1111);
    drive(1, 1'b1, 1'b1, 16'h0040, 16'h2222);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (m0_gnt) begin order[n] = 0; n++; end
      else if (m1_gnt) begin order[n] = 1; n++; end
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    check("both_count", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("both_order%0d", i), order[i], exp_order[i]);
    repeat (4) @(negedge clk);

    // Reset during ACCESS of an m1 read; port 0 served just before.
    do_access(0, 1'b1, 16'h0050, 16'h5555);
    @(posedge clk); #2;
    drive(1, 1'b1, 1'b0, 16'h0060, 16'h0);
    @(posedge clk);
    wait_gnt(1, gnt_lat);
    check("rst_pre_gnt_lat", gnt_lat, 1);
    #1 rst = 1'b1;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    check("rst_mem_re_drop", mem_re, 1'b0);
    check("rst_m1_gnt_drop", m1_gnt, 1'b0);
    rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (m1_rvalid) rv++;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h0060, 16'h0);
    @(posedge clk);
    win = -1;
    for (int i = 0; i < 8 && win < 0; i++) begin
      @(negedge clk);
      if (m1_rvalid) rv++;
      if (m0_gnt) win = 0;
      else if (m1_gnt) win = 1;
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    check("rst_no_m1_rvalid", rv, 0);
    check("rst_tie_winner", win, 0);
    repeat (4) @(negedge clk);

    // m1 withdraws its request right after it is latched.
    @(posedge clk); #2;
    drive(1, 1'b1, 1'b0, 16'h0044, 16'h0);
    @(posedge clk); #2;
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    gc = 0; rv = 0; rd = 16'h0;
    repeat (8) begin
      @(negedge clk);
      if (m1_gnt) gc++;
      if (m1_rvalid) begin rv++; rd = m1_rdata; end
    end
    check("wd_gnt_cnt", gc, 1);
    check("wd_rvalid_cnt", rv, 1);
    check("wd_rdata", rd, 16'hA544);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory. Port 0 is the CPU load/store path and port 1 is the loader/debug path. Each port uses a registered req/gnt handshake. The arbiter owns the memory strobes, so only one requester touches the data memory in any cycle. Read data is returned through a registered response, and arbitration is round-robin unless fixed priority is compiled in.

## Interface
- ADDR_W, 16, byte address width of both requesters and the memory port
- DATA_W, 16, data width
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-high
- m0_req / m1_req  in  1  access request; held high until the matching gnt is seen
- m0_we / m1_we  in  1  1 = write, 0 = read; valid while req is high
- m0_addr / m1_addr  in  ADDR_W  access address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  one-cycle pulse: the request was issued to memory this cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: read data is valid
- m0_rdata / m1_rdata  out  DATA_W  registered read data; holds its value until the next read to that port
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr

## Operation
- FSM states:
  - IDLE: sample requests. If any req is high, pick a winner, latch its we/addr/wdata and port id into a command register, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive mem_addr/mem_wdata from the command register. Assert mem_we or mem_re for exactly this cycle. Pulse the winner's gnt. For a read, capture mem_rdata into the winner's rdata register. Always go to RESP.
  - RESP: pulse the winner's rvalid if the access was a read. Update the last-served pointer. Go to IDLE.
- Round-robin arbitration:
  - The last-served pointer resets to 1, so port 0 wins the first tie.
  - On a tie, the port that was not last served wins.
  - A lone requester always wins.
- Once latched, a command completes even if req drops. A req that drops while in IDLE before being sampled is never issued.
- Writes produce gnt only; rvalid is never asserted for a write.
- Addresses and data pass through unmodified, with no width conversion.
- Outside ACCESS, mem_we = mem_re = 0. mem_addr and mem_wdata hold the last command.
- At most one of m0_gnt/m1_gnt is high in any cycle; the same holds for m0_rvalid/m1_rvalid.

## Timing
- Reset values:
  - state = IDLE, pointer = 1, all command registers 0.
  - mem_addr, mem_wdata, m0_rdata, m1_rdata = 0.
  - All gnt, rvalid, mem_we, mem_re = 0.
- Latency: a req sampled high in IDLE at edge N gives ACCESS and gnt in cycle N+1, and RESP and rvalid in cycle N+2. The next IDLE sample happens at edge N+3.
- Throughput: one access per 3 cycles.
- A requester that stays high after gnt is treated as a new request at the next IDLE sample.
- Reset asserted mid-ACCESS or mid-RESP:
  - Strobes, gnt and rvalid drop immediately, asynchronously.
  - The in-flight access is abandoned and no rvalid is issued.
  - After reset release, arbitration restarts from the reset pointer.
- Back-to-back requests from both ports alternate strictly: 0, 1, 0, 1...

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie. The pointer is not implemented, and port 1 can be starved while m0_req stays high.
- DMEM_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Test plan
- After reset, with no requests for 10 cycles: all outputs stay 0 and mem strobes never assert.
- Port 0 write:
  - Stimulus: m0 writes 0xBEEF to 0x0010.
  - Response: one cycle later mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF and m0_gnt=1; no m0_rvalid.
- Port 0 read-back:
  - Stimulus: m0 then reads 0x0010.
  - Response: m0_rvalid pulses 2 cycles after the sample, with m0_rdata=0xBEEF.
- Both ports request continuously:
  - Stimulus: m0_req and m1_req held high for 4 accesses.
  - Response: grant order is 0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- Reset during ACCESS of an m1 read: mem_re and m1_gnt drop the same cycle, there is no m1_rvalid, and the next tie after reset goes to port 0.
- Request withdrawal: m1_req drops after being latched. The access still completes with m1_gnt and m1_rvalid, and m1 is not re-issued.
